fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly downstream of the program counter register. Consumes the current PC and issues one instruction-memory request per instruction over a req/ack handshake that tolerates variable latency. Returns the PC write enable, so the PC advances only when an instruction has actually been fetched or a redirect occurs. Holds the IF/ID output register with a one-entry skid buffer, honouring decode stall and branch flush.

Parameters:
ADDR_WIDTH, 64, width of PC and instruction address
INSTR_WIDTH, 32, width of fetched instruction word
PC_INC, 4, byte increment for sequential fetch

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
pc_in  input  ADDR_WIDTH  current PC from program counter register
pc_advance  output  1  PC write enable (PC loads next value at this edge)
imem_req  output  1  instruction memory request valid
imem_addr  output  ADDR_WIDTH  request address
imem_ack  input  1  memory response valid, qualifies imem_rdata this cycle
imem_rdata  input  INSTR_WIDTH  fetched instruction
id_stall  input  1  decode cannot accept; hold IF/ID contents
flush  input  1  branch redirect; kill in-flight/buffered fetches
if_valid  output  1  IF/ID register holds a live instruction
if_instr  output  INSTR_WIDTH  IF/ID instruction
if_pc  output  ADDR_WIDTH  PC of if_instr
if_pc_plus4  output  ADDR_WIDTH  if_pc + PC_INC, modulo 2^ADDR_WIDTH

Behaviour:
- Reset (sync, high): state=IDLE; if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0; skid empty; imem_req=0; pc_advance=0. Reset overrides everything, including a pending request; any ack arriving during reset is ignored.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: outputs idle; next state REQ unconditionally (first request one cycle after reset deasserts).
- REQ: imem_req=1, imem_addr=pc_in (combinational); req_addr<=pc_in every cycle. Once asserted, a request is held until ack and never abandoned.
  - ack & flush: data discarded; pc_advance=1; if_valid<=0; stay REQ.
  - ack & !flush & (!if_valid | !id_stall): if_instr<=imem_rdata, if_pc<=pc_in, if_pc_plus4<=pc_in+PC_INC, if_valid<=1; pc_advance=1; stay REQ. This gives back-to-back fetch, one instruction per ack.
  - ack & !flush & if_valid & id_stall: capture into skid (instr, pc, pc+4); pc_advance=1; go HOLD.
  - !ack & flush: pc_advance=1; if_valid<=0; go DRAIN.
  - !ack & !flush: pc_advance=0; if if_valid & !id_stall then if_valid<=0 (consumed).
- HOLD: imem_req=0, pc_advance=0.
  - flush: skid and output invalidated, go REQ.
  - !id_stall: skid moves to IF/ID, if_valid stays 1, go REQ.
  - Otherwise hold.
- DRAIN: imem_req=1, imem_addr=req_addr (pre-flush address); pc_advance=0. On ack, data discarded, go REQ. A further flush during DRAIN is absorbed: pc_advance=1, stay DRAIN.
- flush has priority over id_stall and over ack capture.
- While if_valid & id_stall, the if_* outputs are bit-stable.
- pc_advance is combinational from state and inputs; zero-cycle latency to the PC enable.
- Fetch latency: instruction visible on if_* the cycle after its ack.
- Address arithmetic wraps at 2^ADDR_WIDTH (0xFFFF_FFFF_FFFF_FFFC + 4 = 0).

Optional Feature:
FETCH_PERF_EN. When defined, adds output perf_stall_cnt (32-bit). The counter increments on every cycle where imem_req=1 & !imem_ack, or state==HOLD. It saturates at 0xFFFF_FFFF and clears on reset. When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset with ack tied high, pc_in tracking a PC model from 0: first imem_req in cycle 1 after reset release, addr 0. Then addr 0, 4, 8 on consecutive cycles with pc_advance=1 each cycle; if_pc = 0, 4, 8 one cycle after each ack.
- Ack delayed 3 cycles at pc=0x40: imem_req/imem_addr=0x40 held stable 3 cycles, pc_advance=0 throughout. Ack cycle: pc_advance=1; next cycle if_instr=rdata, if_pc=0x40, if_pc_plus4=0x44.
- id_stall=1 with if_valid=1, then ack at pc=0x48: state HOLD, if_* unchanged, imem_req=0. Drop stall: next cycle if_pc=0x48, then request to 0x4C resumes.
- flush while request to 0x50 is pending with no ack: PC loads 0x200, DRAIN keeps imem_addr=0x50. Ack 2 cycles later is discarded (if_valid=0). Next request goes to 0x200.
- flush and ack in the same cycle at pc=0x60: instruction dropped, if_valid=0 next cycle, next imem_addr = redirected PC.
- Wrap: pc_in=0xFFFF_FFFF_FFFF_FFFC with ack gives if_pc_plus4=0. Reset asserted mid-DRAIN clears if_valid and imem_req on the next edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: req/ack instruction-memory handshake, IF/ID register with a one-entry skid buffer.
// Optional feature macro FETCH_PERF_EN adds a saturating stall-cycle counter on perf_stall_cnt.
module fetch_unit #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_INC      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  output logic                   pc_advance,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   id_stall,
  input  logic                   flush,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic [ADDR_WIDTH-1:0]  if_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_stall_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [ADDR_WIDTH-1:0]  pc_seq;

  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0]  skid_pc;
  logic [ADDR_WIDTH-1:0]  skid_pc_plus4;
  logic                   skid_load;

  // Sequential successor wraps naturally at 2^ADDR_WIDTH.
  assign pc_seq = pc_in + INC;

  // A fetch lands in the skid only when IF/ID is occupied and decode is stalled.
  assign skid_load = (state == REQ) && imem_ack && !flush && if_valid && id_stall;

  // Request and PC-enable are combinational so the PC reacts in the same cycle as the ack.
  // NOTE: every output of an always_comb gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = pc_in;
    pc_advance = 1'b0;
    if (!reset) begin
      case (state)
        REQ: begin
          imem_req   = 1'b1;
          pc_advance = imem_ack | flush;
        end
        DRAIN: begin
          imem_req   = 1'b1;
          imem_addr  = req_addr;
          pc_advance = flush;
        end
        default: begin
          imem_req   = 1'b0;
          pc_advance = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_addr    <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;

        REQ: begin
          req_addr <= pc_in;
          if (flush) begin
            // Redirect wins over capture; an unanswered request must still be drained.
            if_valid <= 1'b0;
            if (!imem_ack) state <= DRAIN;
          end else if (imem_ack) begin
            if (!if_valid || !id_stall) begin
              if_valid    <= 1'b1;
              if_instr    <= imem_rdata;
              if_pc       <= pc_in;
              if_pc_plus4 <= pc_seq;
            end else begin
              state <= HOLD;
            end
          end else if (if_valid && !id_stall) begin
            if_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (flush) begin
            if_valid <= 1'b0;
            state    <= REQ;
          end else if (!id_stall) begin
            if_instr    <= skid_instr;
            if_pc       <= skid_pc;
            if_pc_plus4 <= skid_pc_plus4;
            state       <= REQ;
          end
        end

        DRAIN: begin
          // The pre-flush response is discarded; the redirected PC is fetched next.
          if (imem_ack) state <= REQ;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: skid payload is not reset; it is only ever read in HOLD, which can be
  // reached solely through a fresh capture, so its power-up value is never observed.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_instr    <= imem_rdata;
      skid_pc       <= pc_in;
      skid_pc_plus4 <= pc_seq;
    end
  end

`ifdef FETCH_PERF_EN
  // Counts cycles lost waiting on memory or on a full IF/ID + skid pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
    end else if (((imem_req && !imem_ack) || (state == HOLD)) && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit: a queue-level fetch model predicts requests,
// PC enables and the stream of instructions handed to decode.
module tb_fetch_unit;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam logic [AW-1:0] INC = 64'd4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc_in = '0;
  logic          pc_advance;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          id_stall = 1'b0;
  logic          flush = 1'b0;
  logic          if_valid;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_pc_plus4;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .PC_INC     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_advance (pc_advance),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_stall   (id_stall),
    .flush      (flush),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_plus4(if_pc_plus4)
  );

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
  } fetch_t;

  fetch_t exp_q[$];
  fetch_t got;
  int n_vec = 0;
  int n_err = 0;

  // Reference model: fetched-but-unconsumed instructions (occ), an abandoned request being
  // drained (dead / dead_addr), and the PC register the fetch stage drives.
  logic [AW-1:0] pc_next   = '0;
  logic [AW-1:0] redirect  = '0;
  logic [AW-1:0] dead_addr = '0;
  bit started = 1'b0;
  bit dead    = 1'b0;
  bit armed   = 1'b0;
  int occ     = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit live;
    bit cons;
    logic exp_req;
    logic exp_adv;
    logic [AW-1:0] exp_addr;
    if (reset) begin
      if (armed) begin
        check("imem_req_in_reset", imem_req, 1'b0);
        check("pc_advance_in_reset", pc_advance, 1'b0);
      end
      started = 1'b0;
      dead    = 1'b0;
      occ     = 0;
      exp_q.delete();
      pc_next = '0;
      armed   = 1'b1;
      return;
    end
    check("if_valid", if_valid, occ > 0);
    live     = started && !dead && (occ < 2);
    exp_req  = started && (dead || (occ < 2));
    exp_addr = dead ? dead_addr : pc_in;
    exp_adv  = live ? (imem_ack | flush) : (dead & flush);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, exp_addr);
    check("pc_advance", pc_advance, exp_adv);
    pc_next = exp_adv ? (flush ? redirect : pc_in + INC) : pc_in;
    cons = (occ > 0) && !id_stall && !flush;
    if (!started) begin
      started = 1'b1;
    end else if (live) begin
      if (flush) begin
        occ = 0;
        exp_q.delete();
        if (!imem_ack) begin
          dead      = 1'b1;
          dead_addr = pc_in;
        end
      end else if (imem_ack) begin
        exp_q.push_back(fetch_t'{imem_rdata, pc_in, pc_in + INC});
        occ = occ - int'(cons) + 1;
      end else begin
        occ = occ - int'(cons);
      end
    end else if (dead) begin
      if (imem_ack) dead = 1'b0;
    end else if (flush) begin
      occ = 0;
      exp_q.delete();
    end else begin
      occ = occ - int'(cons);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    model_step();
  end

  // Monitor: every instruction decode actually takes must be the next one the model expects.
  always @(negedge clk) begin
    if (armed && !reset && if_valid && !id_stall && !flush) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL consume: unexpected instr %h pc %h at %0t", if_instr, if_pc, $time);
      end else begin
        got = exp_q.pop_front();
        check("if_instr", {32'd0, if_instr}, {32'd0, got.instr});
        check("if_pc", if_pc, got.pc);
        check("if_pc_plus4", if_pc_plus4, got.pc4);
      end
    end
  end

  task automatic cycle(input bit rst, input bit want_ack, input bit stall, input bit fl,
                       input logic [AW-1:0] tgt);
    @(posedge clk);
    #1;
    pc_in      = pc_next;
    reset      = rst;
    imem_ack   = want_ack && !rst && started && (dead || (occ < 2));
    imem_rdata = $urandom;
    id_stall   = stall;
    flush      = fl;
    redirect   = tgt;
  endtask

  logic [AW-1:0] tgt;

  initial begin
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    #6;
    check("reset_if_valid", if_valid, 1'b0);
    check("reset_if_instr", {32'd0, if_instr}, '0);
    check("reset_if_pc", if_pc, '0);
    check("reset_if_pc_plus4", if_pc_plus4, '0);
    check("reset_imem_req", imem_req, 1'b0);

    // Back-to-back fetch with ack tied high.
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    // Flush with simultaneous ack redirects to 0x40, then a 3-cycle-late ack.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'h40);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    // Decode stall with a live IF/ID entry pushes the next fetch into the skid.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    repeat (2) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    // Flush against a pending request, late ack is drained and discarded.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h200);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    // Address wrap at the top of the address space.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    #6;
    check("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_if_pc_plus4", if_pc_plus4, '0);
    // Reset while draining.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h300);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #6;
    check("rst_drain_if_valid", if_valid, 1'b0);
    check("rst_drain_imem_req", imem_req, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) tgt[AW-1:8] = '1;
      tgt[1:0] = 2'b00;
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 8, tgt);
    end
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    #2;
    check("scoreboard_residue", 64'(exp_q.size()), 64'(occ));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
